// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   Load/store request bus between the CPU memory initiator (master) and the
//   memory responder (slave). One request is in flight at a time.
//
//   req    master->slave  request valid, sampled only while the responder idles
//   wr     master->slave  1 = store, 0 = load
//   size   master->slave  00 word, 01 halfword, 10 byte, 11 word
//   addr   master->slave  byte address
//   wdata  master->slave  store data, right-aligned for byte/halfword
//   ack    slave->master  one-cycle completion pulse
//   rdata  slave->master  full read word, nonzero only while ack=1
//   busy   slave->master  high from acceptance through the ack cycle
//   fault  slave->master  qualifies ack: access rejected
// ---------------------------------------------------------------------------
interface mem_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
    logic        fault;

    modport master (
        output req, wr, size, addr, wdata,
        input  ack, rdata, busy, fault
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output ack, rdata, busy, fault
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU load/store port. Accepts one request at
//   a time, models READ_LAT wait cycles for array reads, and performs byte and
//   halfword stores as read-modify-write on a word-wide array. Loads always
//   return the full word; lane extraction is done by the requester.
//
//   Parameters
//     ADDR_BITS  word-index width, array depth = 2**ADDR_BITS words
//     READ_LAT   wait cycles for an array read, 1..15
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous active-low reset (array contents are kept)
//     bus    mem_responder_if.slave request/response bus
//
//   Build option
//     MEM_RANGE_CHECK_EN  when defined, any address with bits above the array
//                         index set is rejected with fault; otherwise those
//                         bits are ignored and addresses wrap.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int READ_LAT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus
);

    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WORD,
        RMW_WAIT,
        RMW_WRITE,
        FAULT,
        RESP
    } state_t;

    state_t state_reg, state_next;

    logic [3:0]           cnt_reg, cnt_next;
    logic [ADDR_BITS+1:0] addr_reg;
    logic                 wr_reg;
    logic [1:0]           size_reg;
    logic [31:0]          wdata_reg;
    logic                 err_reg;

    logic                 accept;
    logic                 misalign;
    logic                 range_err;
    logic                 req_err;
    logic                 word_size;

    logic [31:0]          mem [0:DEPTH-1];
    logic [31:0]          rd_word_reg;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] idx;

    logic [3:0]           be;
    logic [31:0]          wlane;
    logic [31:0]          merged;

    // ------------------------------------------------------------------
    // Request decode (combinational on the live bus, used only at accept)
    // ------------------------------------------------------------------
    assign accept    = (state_reg == IDLE) && bus.req;
    assign word_size = (bus.size == 2'b00) || (bus.size == 2'b11);

    always_comb begin
        misalign = 1'b0;
        case (bus.size)
            2'b01:   misalign = bus.addr[0];
            2'b10:   misalign = 1'b0;
            default: misalign = (bus.addr[1:0] != 2'b00);
        endcase
    end

`ifdef MEM_RANGE_CHECK_EN
    assign range_err = (bus.addr >> (ADDR_BITS + 2)) != 32'd0;
`else
    // Upper address bits are deliberately ignored so accesses wrap.
    logic unused_upper_addr;
    assign unused_upper_addr = ^bus.addr[31:ADDR_BITS+2];
    assign range_err         = 1'b0;
`endif

    assign req_err = misalign | range_err;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    if (req_err)
                        state_next = FAULT;
                    else if (!bus.wr)
                        state_next = RD_WAIT;
                    else if (word_size)
                        state_next = WR_WORD;
                    else
                        state_next = RMW_WAIT;
                end
            end
            RD_WAIT:   if (cnt_reg == 4'd0) state_next = RESP;
            WR_WORD:   state_next = RESP;
            RMW_WAIT:  if (cnt_reg == 4'd0) state_next = RMW_WRITE;
            RMW_WRITE: state_next = RESP;
            FAULT:     state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Everything on the response side is gated by RESP so
    // rdata and fault stay zero outside the ack cycle.
    // ------------------------------------------------------------------
    always_comb begin
        bus.ack   = (state_reg == RESP);
        bus.busy  = (state_reg != IDLE);
        bus.fault = (state_reg == RESP) && err_reg;
        bus.rdata = 32'd0;
        if ((state_reg == RESP) && !wr_reg && !err_reg)
            bus.rdata = rd_word_reg;
        mem_we    = (state_reg == WR_WORD) || (state_reg == RMW_WRITE);
    end

    // ------------------------------------------------------------------
    // Wait counter: loaded with READ_LAT-1 at accept so that the final
    // wait-state edge lands exactly READ_LAT edges after acceptance.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt_reg;
        if (accept)
            cnt_next = LAT_M1;
        else if (((state_reg == RD_WAIT) || (state_reg == RMW_WAIT)) && (cnt_reg != 4'd0))
            cnt_next = cnt_reg - 4'd1;
    end

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            wr_reg    <= 1'b0;
            size_reg  <= 2'b00;
            wdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (accept) begin
                addr_reg  <= bus.addr[ADDR_BITS+1:0];
                wr_reg    <= bus.wr;
                size_reg  <= bus.size;
                wdata_reg <= bus.wdata;
                err_reg   <= req_err;
            end
        end
    end

    assign idx = addr_reg[ADDR_BITS+1:2];

    // ------------------------------------------------------------------
    // Lane merge. A word store enables all four lanes, so the merged word
    // is simply wdata and does not depend on the read-back value.
    // ------------------------------------------------------------------
    always_comb begin
        case (size_reg)
            2'b10: begin
                be    = 4'b0001 << addr_reg[1:0];
                wlane = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                be    = addr_reg[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_reg[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_reg;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = be[gi] ? wlane[gi*8 +: 8] : rd_word_reg[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Word array with registered read. The read port tracks the latched
    // index every cycle; by the end of the wait states it holds the word.
    // Writes happen only in WR_WORD/RMW_WRITE, so a reset that returns the
    // FSM to IDLE also cancels any pending write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= merged;
        rd_word_reg <= mem[idx];
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int ADDR_BITS = 8;
    localparam int READ_LAT  = 2;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mem_responder_if bus();

    mem_responder #(
        .ADDR_BITS (ADDR_BITS),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction. Entered on a falling edge; returns on the
    // falling edge after the cycle following ack.
    task automatic xact(input string tag, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_fault,
                        input logic [31:0] exp_rdata);
        int   k;
        logic quiet_ok;
        bus.req   = 1'b1;
        bus.wr    = w;
        bus.size  = sz;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req  = 1'b0;
        k        = 0;
        quiet_ok = 1'b1;
        while (bus.ack !== 1'b1 && k < 40) begin
            if (bus.busy !== 1'b1 || bus.fault !== 1'b0 || bus.rdata !== 32'd0)
                quiet_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(exp_lat));
        chk({tag, " wait_outputs"}, {31'd0, quiet_ok}, 32'd1);
        chk({tag, " busy_in_ack"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, " fault"}, {31'd0, bus.fault}, {31'd0, exp_fault});
        chk({tag, " rdata"}, bus.rdata, exp_rdata);
        $display("xact %s wr=%0b size=%0d addr=%h wdata=%h lat=%0d fault=%0b rdata=%h",
                 tag, w, sz, a, d, k, bus.fault, bus.rdata);
        @(negedge clk);
        chk({tag, " idle_after"}, {29'd0, bus.ack, bus.busy, bus.fault}, 32'd0);
    endtask

    logic [16:0] ack_mask;
    logic [16:0] busy_mask;
    logic        rd_ok;

    initial begin
        reset     = 1'b0;
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.size  = 2'b00;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;

        // Reset held low for three cycles
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.ack, bus.busy, bus.fault, bus.rdata}, 35'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {29'd0, bus.ack, bus.busy, bus.fault}, 32'd0);

        // Word store / load
        xact("st_word_10", 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'd0);
        xact("ld_word_10", 1'b0, 2'b00, 32'h10, 32'd0, 2, 1'b0, 32'hDEADBEEF);

        // Byte RMW into lane 2
        xact("st_word_20a", 1'b1, 2'b00, 32'h20, 32'h11223344, 1, 1'b0, 32'd0);
        xact("st_byte_22", 1'b1, 2'b10, 32'h22, 32'h000000AA, 3, 1'b0, 32'd0);
        xact("ld_after_byte22", 1'b0, 2'b00, 32'h20, 32'd0, 2, 1'b0, 32'h11AA3344);

        // Halfword RMW upper lane
        xact("st_word_20b", 1'b1, 2'b00, 32'h20, 32'h11223344, 1, 1'b0, 32'd0);
        xact("st_half_22", 1'b1, 2'b01, 32'h22, 32'h0000BEEF, 3, 1'b0, 32'd0);
        xact("ld_after_half22", 1'b0, 2'b00, 32'h20, 32'd0, 2, 1'b0, 32'hBEEF3344);

        // Halfword RMW lower lane
        xact("st_word_20c", 1'b1, 2'b00, 32'h20, 32'h11223344, 1, 1'b0, 32'd0);
        xact("st_half_20", 1'b1, 2'b01, 32'h20, 32'h0000CAFE, 3, 1'b0, 32'd0);
        xact("ld_after_half20", 1'b0, 2'b00, 32'h20, 32'd0, 2, 1'b0, 32'h1122CAFE);

        // Byte into top lane; upper wdata bits must be ignored
        xact("st_word_20d", 1'b1, 2'b00, 32'h20, 32'h11223344, 1, 1'b0, 32'd0);
        xact("st_byte_23", 1'b1, 2'b10, 32'h23, 32'hFFFFFF77, 3, 1'b0, 32'd0);
        xact("ld_after_byte23", 1'b0, 2'b00, 32'h20, 32'd0, 2, 1'b0, 32'h77223344);

        // Misaligned accesses
        xact("st_half_21_misal", 1'b1, 2'b01, 32'h21, 32'h00001234, 1, 1'b1, 32'd0);
        xact("ld_after_misal", 1'b0, 2'b00, 32'h20, 32'd0, 2, 1'b0, 32'h77223344);
        xact("ld_word_26_misal", 1'b0, 2'b00, 32'h26, 32'd0, 1, 1'b1, 32'd0);

        // Loads of any size return the full word
        xact("ld_size11_20", 1'b0, 2'b11, 32'h20, 32'd0, 2, 1'b0, 32'h77223344);
        xact("ld_byte_23", 1'b0, 2'b10, 32'h23, 32'd0, 2, 1'b0, 32'h77223344);

        // size=11 store behaves as a word store
        xact("st_size11_24", 1'b1, 2'b11, 32'h24, 32'h0BADF00D, 1, 1'b0, 32'd0);
        xact("ld_word_24", 1'b0, 2'b00, 32'h24, 32'd0, 2, 1'b0, 32'h0BADF00D);

        // req held high for 12 edges: accepts at edges 1,5,9, acks after 3,7,11
        ack_mask  = '0;
        busy_mask = '0;
        rd_ok     = 1'b1;
        bus.req   = 1'b1;
        bus.wr    = 1'b0;
        bus.size  = 2'b00;
        bus.addr  = 32'h20;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ack_mask[k]  = bus.ack;
            busy_mask[k] = bus.busy;
            if (bus.ack === 1'b1 && bus.rdata !== 32'h77223344)
                rd_ok = 1'b0;
            if (k == 12)
                bus.req = 1'b0;
        end
        $display("held_req ack_mask=%h busy_mask=%h", ack_mask, busy_mask);
        chk("held_req ack_mask", {15'd0, ack_mask}, 32'h00888);
        chk("held_req busy_mask", {15'd0, busy_mask}, 32'h00EEE);
        chk("held_req rdata", {31'd0, rd_ok}, 32'd1);

        // req pulsed while busy is ignored
        ack_mask  = '0;
        busy_mask = '0;
        bus.req   = 1'b1;
        bus.addr  = 32'h10;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ack_mask[k]  = bus.ack;
            busy_mask[k] = bus.busy;
            if (k == 1) bus.req = 1'b0;
            if (k == 2) bus.req = 1'b1;
            if (k == 3) bus.req = 1'b0;
        end
        $display("pulse_busy ack_mask=%h busy_mask=%h", ack_mask, busy_mask);
        chk("pulse_busy ack_mask", {15'd0, ack_mask}, 32'h008);
        chk("pulse_busy busy_mask", {15'd0, busy_mask}, 32'h00E);

        // Reset during RMW_WAIT cancels the pending write
        xact("st_word_30", 1'b1, 2'b00, 32'h30, 32'h00000000, 1, 1'b0, 32'd0);
        bus.req   = 1'b1;
        bus.wr    = 1'b1;
        bus.size  = 2'b10;
        bus.addr  = 32'h30;
        bus.wdata = 32'h000000FF;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        chk("rmw_busy_before_reset", {31'd0, bus.busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_reset_outputs", {bus.ack, bus.busy, bus.fault, bus.rdata}, 35'd0);
        $display("reset asserted during RMW_WAIT busy=%0b", bus.busy);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xact("ld_after_abort_30", 1'b0, 2'b00, 32'h30, 32'd0, 2, 1'b0, 32'h00000000);

        // Wrap vs range check
        xact("st_word_00", 1'b1, 2'b00, 32'h0, 32'h01234567, 1, 1'b0, 32'd0);
`ifdef MEM_RANGE_CHECK_EN
        xact("st_word_400", 1'b1, 2'b00, 32'h400, 32'h5A5A5A5A, 1, 1'b1, 32'd0);
        xact("ld_word_00_after", 1'b0, 2'b00, 32'h0, 32'd0, 2, 1'b0, 32'h01234567);
`else
        xact("st_word_400", 1'b1, 2'b00, 32'h400, 32'h5A5A5A5A, 1, 1'b0, 32'd0);
        xact("ld_word_00_after", 1'b0, 2'b00, 32'h0, 32'd0, 2, 1'b0, 32'h5A5A5A5A);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
